vload_slot_sched: RTL

Scheduler for a pool of vector-load writeback slots. Each slot tracks one in-flight vector load: the destination register line it writes next and the beats remaining. The block allocates a slot per issued load, tags returning memory beats back to VRF write addresses, and frees the slot on the last beat. It sits between the vector decode/issue stage, the load-return path and the VRF write port.

---
 rtl/vload_slot_sched.sv | 115 +++++++++++
 1 files changed

// File: rtl/vload_slot_sched.sv
`default_nettype none
// ============================================================================
// Module   : vload_slot_sched
// Purpose  : Writeback slot scheduler for in-flight vector loads. It allocates
//            a slot per issued load, maps each returned beat to a VRF line
//            address, and frees the slot on its last beat.
// Revision : 1.0 - initial release
// ============================================================================
module vload_slot_sched #(
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_W     = $clog2(NUM_SLOTS),
  parameter int ADDR_WIDTH = 5,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] issue_vd,
  input  logic [LEN_WIDTH-1:0]  issue_beats,
  output logic [SLOT_W-1:0]     issue_slot,
  input  logic                  resp_valid,
  input  logic [SLOT_W-1:0]     resp_slot,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [SLOT_W-1:0]     wr_slot,
  output logic                  done_valid,
  output logic [SLOT_W-1:0]     done_slot,
  output logic                  resp_err,
  output logic [NUM_SLOTS-1:0]  slot_busy,
  output logic                  busy
);

  // Per-slot tracking state
  logic [NUM_SLOTS-1:0]  r_busy;
  logic [ADDR_WIDTH-1:0] r_addr [NUM_SLOTS];
  logic [LEN_WIDTH-1:0]  r_rem  [NUM_SLOTS];

  logic [SLOT_W-1:0]     w_free_slot;
  logic                  w_issue_fire;
  logic                  w_resp_hit;
  logic                  w_last_beat;

  // Lowest-index idle slot; scanning downward lets the lowest index win.
  always_comb begin
    w_free_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_slot = SLOT_W'(i);
      end
    end
  end

  // Ready depends only on registered busy, so a slot freed this cycle is
  // not offered until the next one.
  assign issue_ready  = ~(&r_busy) & ~flush;
  assign issue_slot   = w_free_slot;
  assign w_issue_fire = issue_valid & issue_ready;
  assign w_resp_hit   = resp_valid & r_busy[resp_slot];
  assign w_last_beat  = (r_rem[resp_slot] == LEN_WIDTH'(1));
  assign slot_busy    = r_busy;
  assign busy         = |r_busy;

  // Slot state update and registered writeback/done/error pulses.
  // An issued slot is always idle and a hit slot is always busy, so the
  // issue and response updates never target the same slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_addr[i] <= '0;
        r_rem[i]  <= '0;
      end
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_slot    <= '0;
      done_valid <= 1'b0;
      done_slot  <= '0;
      resp_err   <= 1'b0;
    end else if (flush) begin
      r_busy     <= '0;
      wr_valid   <= 1'b0;
      done_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      wr_valid   <= 1'b0;
      done_valid <= 1'b0;
      resp_err   <= 1'b0;

      if (w_resp_hit) begin
        wr_valid          <= 1'b1;
        wr_addr           <= r_addr[resp_slot];
        wr_slot           <= resp_slot;
        r_addr[resp_slot] <= r_addr[resp_slot] + ADDR_WIDTH'(1);
        r_rem[resp_slot]  <= r_rem[resp_slot] - LEN_WIDTH'(1);
        if (w_last_beat) begin
          r_busy[resp_slot] <= 1'b0;
          done_valid        <= 1'b1;
          done_slot         <= resp_slot;
        end
      end else if (resp_valid) begin
        resp_err <= 1'b1;
      end

      if (w_issue_fire) begin
        r_busy[w_free_slot] <= 1'b1;
        r_addr[w_free_slot] <= issue_vd;
        r_rem[w_free_slot]  <= issue_beats;
      end
    end
  end

endmodule
`default_nettype wire
